// File: rtl/shift_exec_stage_pkg.sv
// Shared opcode definitions and helpers for the shift execute stage.
// Rotate support is controlled by the SHIFT_EXEC_ROTR_EN macro in shift_exec_stage.
package shift_exec_stage_pkg;

  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    SHIFT_OP_SLL  = 3'b000,
    SHIFT_OP_SRL  = 3'b001,
    SHIFT_OP_SRA  = 3'b010,
    SHIFT_OP_ROTR = 3'b011
  } shift_op_e;

  // A zero rotate returns the operand untouched rather than relying on a 32-bit shift.
  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] n);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, n};
    return (n == 5'd0) ? v : ((v >> n) | (v << inv));
  endfunction

endpackage

// File: rtl/shift_pipe_reg.sv
// Single valid/ready register slice: ready passes straight through from downstream,
// so a full slice still accepts a new beat in the same cycle it drains one.
module shift_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      data_d = in_data;
    end
  end

  // NOTE: the payload is reset as well as the valid bit, because the result bus must read zero
  // straight out of reset; state updates use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sll32.sv
// 32-bit logical left shift; any amount of 32 or more yields zero.
module sll32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Y
);
  assign Y = B << A;
endmodule

// File: rtl/sra32.sv
// 32-bit arithmetic right shift; any amount of 32 or more replicates the sign bit.
module sra32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Y
);
  assign Y = $signed(B) >>> A;
endmodule

// File: rtl/srl32.sv
// 32-bit logical right shift; any amount of 32 or more yields zero.
module srl32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Y
);
  assign Y = B >> A;
endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shifter: S1 captures the operands, S2 captures the selected result.
// Define SHIFT_EXEC_ROTR_EN to make opcode 011 a rotate-right; otherwise it is illegal.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SHIFT_OP_W-1:0] in_op,
  input  logic                  in_use_imm,
  input  logic [4:0]            in_shamt,
  input  logic [31:0]           in_rs,
  input  logic [31:0]           in_rt,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_res,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  localparam int S1_W = SHIFT_OP_W + 32 + 32 + TAG_W;
  localparam int S2_W = 32 + TAG_W + 1;

  logic [31:0]           amount;
  logic [S1_W-1:0]       s1_data;
  logic                  s1_valid, s1_ready;
  logic [SHIFT_OP_W-1:0] s1_op;
  logic [31:0]           s1_amt, s1_rt;
  logic [TAG_W-1:0]      s1_tag;
  logic [31:0]           sll_y, srl_y, sra_y;
  logic [31:0]           res_sel;
  logic                  err_sel;
  logic [S2_W-1:0]       s2_data;

  // The full register value is forwarded so amounts of 32 and above saturate in the shifters.
  assign amount = in_use_imm ? {27'b0, in_shamt} : in_rs;

  shift_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, amount, in_rt, in_tag}),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_data)
  );

  assign {s1_op, s1_amt, s1_rt, s1_tag} = s1_data;

  sll32 u_sll (.A(s1_amt), .B(s1_rt), .Y(sll_y));
  srl32 u_srl (.A(s1_amt), .B(s1_rt), .Y(srl_y));
  sra32 u_sra (.A(s1_amt), .B(s1_rt), .Y(sra_y));

  always_comb begin
    res_sel = '0;
    err_sel = 1'b0;
    case (s1_op)
      SHIFT_OP_SLL:  res_sel = sll_y;
      SHIFT_OP_SRL:  res_sel = srl_y;
      SHIFT_OP_SRA:  res_sel = sra_y;
`ifdef SHIFT_EXEC_ROTR_EN
      SHIFT_OP_ROTR: res_sel = rotr32(s1_rt, s1_amt[4:0]);
`endif
      default:       err_sel = 1'b1;
    endcase
  end

  shift_pipe_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   ({res_sel, s1_tag, err_sel}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_res, out_tag, out_err} = s2_data;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vector table, stall and reset sequences,
// and randomized traffic scored against a bit-level reference model.
module tb_shift_exec_stage;

  typedef struct {
    logic [2:0]  op;
    logic        use_imm;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  tag;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    string       name;
    op_t         o;
    logic [31:0] res;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_use_imm;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
  logic        out_err;

  shift_exec_stage #(.TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_use_imm (in_use_imm),
    .in_shamt   (in_shamt),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          emit_cnt = 0;
  bit          lat_chk = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_res;
  logic [4:0]  hold_tag;
  logic        hold_err;
  exp_t        sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: each result bit is picked from its source bit by index arithmetic.
  function automatic exp_t model(input op_t o);
    exp_t   e;
    longint a;
    longint src;
    int     n;
    a = o.use_imm ? {59'b0, o.shamt} : {32'b0, o.rs};
    e.res = '0;
    e.err = 1'b0;
    e.tag = o.tag;
    e.acc_cyc = 0;
    case (o.op)
      3'd0: for (int i = 0; i < 32; i++) begin
        src = longint'(i) - a;
        if (src >= 0) e.res[i] = o.rt[int'(src)];
      end
      3'd1: for (int i = 0; i < 32; i++) begin
        src = longint'(i) + a;
        if (src < 32) e.res[i] = o.rt[int'(src)];
      end
      3'd2: for (int i = 0; i < 32; i++) begin
        src = longint'(i) + a;
        e.res[i] = (src < 32) ? o.rt[int'(src)] : o.rt[31];
      end
`ifdef SHIFT_EXEC_ROTR_EN
      3'd3: begin
        n = int'(a % 32);
        for (int i = 0; i < 32; i++) e.res[i] = o.rt[(i + n) % 32];
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic [2:0] op, input logic use_imm,
                                  input logic [4:0] shamt, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [4:0] tag,
                                  input logic [31:0] res, input logic err);
    vec_t v;
    v.name = name;
    v.o.op = op; v.o.use_imm = use_imm; v.o.shamt = shamt;
    v.o.rs = rs; v.o.rt = rt; v.o.tag = tag;
    v.res = res; v.err = err;
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.op      = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    o.use_imm = 1'($urandom_range(0, 1));
    o.shamt   = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       o.rs = 32'($urandom_range(0, 40));
      1:       o.rs = 32'd32;
      2:       o.rs = 32'd31;
      default: o.rs = $urandom;
    endcase
    o.rt  = $urandom;
    o.tag = 5'($urandom);
    return o;
  endfunction

  task automatic present(input op_t o);
    in_op = o.op; in_use_imm = o.use_imm; in_shamt = o.shamt;
    in_rs = o.rs; in_rt = o.rt; in_tag = o.tag;
  endtask

  // One cycle: sample just after the falling edge, score outputs, log acceptance, advance.
  task automatic step(input exp_t e, output bit acc);
    exp_t ex;
    #1;
    acc = in_valid && in_ready;
    if (hold_pend) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_res", out_res, hold_res);
      check("stall_tag", 32'(out_tag), 32'(hold_tag));
      check("stall_err", 32'(out_err), 32'(hold_err));
    end
    hold_pend = out_valid && !out_ready;
    hold_res = out_res; hold_tag = out_tag; hold_err = out_err;
    if (out_valid && out_ready) begin
      emit_cnt++;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got res 0x%08h tag %0d, expected no output", out_res, out_tag);
      end else begin
        ex = sb.pop_front();
        check("res", out_res, ex.res);
        check("tag", 32'(out_tag), 32'(ex.tag));
        check("err", 32'(out_err), 32'(ex.err));
        if (lat_chk) check("latency", 32'(cyc - ex.acc_cyc), 32'd2);
      end
    end
    if (acc) begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish within time budget");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    exp_t e;
    exp_t idle;
    op_t  cur;
    op_t  pend[$];
    op_t  a_op;
    bit   acc;
    bit   have;
    int   base;
    logic [31:0] rotr_res;
    logic        rotr_err;
    logic [31:0] rot0_res;

`ifdef SHIFT_EXEC_ROTR_EN
    rotr_res = 32'h1000_000F; rotr_err = 1'b0; rot0_res = 32'h0000_ABCD;
`else
    rotr_res = 32'h0;         rotr_err = 1'b1; rot0_res = 32'h0;
`endif
    vecs[0]  = mk_vec("sll_imm4",     3'b000, 1'b1, 5'd4,  32'h0,        32'h0000_0001, 5'd3,  32'h0000_0010, 1'b0);
    vecs[1]  = mk_vec("sra_rs40",     3'b010, 1'b0, 5'd0,  32'd40,       32'h8000_0000, 5'd1,  32'hFFFF_FFFF, 1'b0);
    vecs[2]  = mk_vec("srl_rs32",     3'b001, 1'b0, 5'd7,  32'h20,       32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1'b0);
    vecs[3]  = mk_vec("illegal_111",  3'b111, 1'b1, 5'd3,  32'h0,        32'h1234_5678, 5'd9,  32'h0000_0000, 1'b1);
    vecs[4]  = mk_vec("rotr_imm4",    3'b011, 1'b1, 5'd4,  32'h0,        32'h0000_00F1, 5'd4,  rotr_res,      rotr_err);
    vecs[5]  = mk_vec("sll_rs_hi",    3'b000, 1'b0, 5'd0,  32'h0001_0004, 32'h0000_0001, 5'd5, 32'h0000_0000, 1'b0);
    vecs[6]  = mk_vec("sra_pos31",    3'b010, 1'b1, 5'd31, 32'h0,        32'h7FFF_FFFF, 5'd6,  32'h0000_0000, 1'b0);
    vecs[7]  = mk_vec("sra_neg4",     3'b010, 1'b1, 5'd4,  32'h0,        32'h8000_0000, 5'd7,  32'hF800_0000, 1'b0);
    vecs[8]  = mk_vec("srl_zero",     3'b001, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd8, 32'hDEAD_BEEF, 1'b0);
    vecs[9]  = mk_vec("illegal_100",  3'b100, 1'b0, 5'd1,  32'd1,        32'hFFFF_FFFF, 5'd31, 32'h0000_0000, 1'b1);
    vecs[10] = mk_vec("imm_over_rs",  3'b000, 1'b1, 5'd1,  32'hFFFF_FFFF, 32'h0000_0003, 5'd10, 32'h0000_0006, 1'b0);
    vecs[11] = mk_vec("rotr_zero",    3'b011, 1'b1, 5'd0,  32'h0,        32'h0000_ABCD, 5'd11, rot0_res,      rotr_err);

    idle = '{res: 32'h0, tag: 5'h0, err: 1'b0, acc_cyc: 0};
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_use_imm = 1'b0; in_shamt = '0; in_rs = '0; in_rt = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_res",   out_res,        32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one op at a time, with fixed two-cycle latency.
    lat_chk = 1'b1;
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      present(vecs[k].o);
      in_valid = 1'b1;
      e.res = vecs[k].res; e.tag = vecs[k].o.tag; e.err = vecs[k].err; e.acc_cyc = 0;
      step(e, acc);
      check({"accept_", vecs[k].name}, 32'(acc), 32'd1);
      in_valid = 1'b0;
      repeat (3) step(idle, acc);
      check({"drain_", vecs[k].name}, 32'(sb.size()), 32'd0);
    end
    lat_chk = 1'b0;

    // Four back-to-back ops against a 3-cycle downstream stall.
    for (int i = 0; i < 4; i++) begin
      a_op.op = 3'(i % 3); a_op.use_imm = 1'b1; a_op.shamt = 5'(i + 1);
      a_op.rs = '0; a_op.rt = 32'h8000_00F0 + 32'(i); a_op.tag = 5'(20 + i);
      pend.push_back(a_op);
    end
    base = emit_cnt;
    for (int k = 0; k < 30; k++) begin
      out_ready = (k >= 3);
      if (pend.size() > 0) begin
        present(pend[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 3) check("stall_in_ready", 32'(in_ready), (k < 2) ? 32'd1 : 32'd0);
      step((pend.size() > 0) ? model(pend[0]) : idle, acc);
      if (acc) void'(pend.pop_front());
      if (pend.size() == 0 && sb.size() == 0) break;
    end
    check("stall_all_emitted", 32'(emit_cnt - base), 32'd4);

    // Randomized traffic with random back-pressure.
    have = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        cur = rand_op();
        have = 1'b1;
      end
      in_valid = have;
      if (have) present(cur);
      out_ready = ($urandom_range(0, 3) != 0);
      step(have ? model(cur) : idle, acc);
      if (acc) have = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step(idle, acc);
    check("random_drain", 32'(sb.size()), 32'd0);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    cur = rand_op(); cur.op = 3'b000;
    present(cur); in_valid = 1'b1;
    step(model(cur), acc);
    cur.tag = cur.tag + 5'd1;
    present(cur);
    step(model(cur), acc);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    base = emit_cnt;
    repeat (4) step(idle, acc);
    check("midrst_no_emit", 32'(emit_cnt - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
